// File: rtl/fb_scan_out_if.sv
// Frame RAM read port between the scan-out block (master) and the frame memory (slave).
// addr carries {bank, offset}; data is the RGB332 byte for the address presented last step.
interface fb_scan_out_if #(
    parameter int unsigned ADDR_W = 15
);
    logic              rd;
    logic [ADDR_W:0]   addr;
    logic [7:0]        data;

    modport master (output rd, output addr, input data);
    modport slave  (input rd, input addr, output data);
endinterface

// File: rtl/fb_scan_out.sv
// Framebuffer scan-out: maps iterator positions to frame RAM addresses, expands RGB332
// to 12-bit RGB and delays the syncs so they stay aligned with the colour output.
module fb_scan_out #(
    parameter int unsigned H_OFFSET = 160,
    parameter int unsigned FB_W     = 160,
    parameter int unsigned FB_H     = 120,
    parameter int unsigned SCALE    = 4,
    parameter int unsigned ADDR_W   = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pix_clk,
    input  logic [9:0]          pix_x,
    input  logic [9:0]          pix_y,
    input  logic                h_sync,
    input  logic                v_sync,
    input  logic                draw_active,
    input  logic                screen_end,
    fb_scan_out_if.master       fb,
    input  logic                swap_req,
    output logic                swap_ack,
    output logic                front_bank,
    output logic [7:0]          frame_cnt,
    output logic [3:0]          vga_r,
    output logic [3:0]          vga_g,
    output logic [3:0]          vga_b,
    output logic                vga_hs,
    output logic                vga_vs
);

    localparam int unsigned SHIFT = $clog2(SCALE);

    logic [9:0]        col_raw;
    logic [9:0]        col_idx;
    logic [9:0]        y_div;
    logic [9:0]        row_idx;
    logic [ADDR_W-1:0] offset;
    logic              hs_d;
    logic              vs_d;
    logic              swap_armed;
    logic              swap_do;

    function automatic logic [11:0] expand(input logic [7:0] p);
        return {p[7:5], p[7], p[4:2], p[4], p[1:0], p[1:0]};
    endfunction

    always_comb begin
        col_raw = pix_x - 10'(H_OFFSET);
        col_idx = col_raw >> SHIFT;
        y_div   = pix_y >> SHIFT;
        // Guard against an unclamped pix_y ever addressing past the last stored row.
        row_idx = (y_div > 10'(FB_H - 1)) ? 10'(FB_H - 1) : y_div;
        offset  = ADDR_W'(row_idx) * ADDR_W'(FB_W) + ADDR_W'(col_idx);
    end

    // A request held through its own ack must drop low before it can swap again.
    assign swap_do = pix_clk && screen_end && swap_req && swap_armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            fb.rd      <= 1'b0;
            fb.addr    <= '0;
            vga_r      <= '0;
            vga_g      <= '0;
            vga_b      <= '0;
            hs_d       <= 1'b1;
            vs_d       <= 1'b1;
            vga_hs     <= 1'b1;
            vga_vs     <= 1'b1;
            front_bank <= 1'b0;
            frame_cnt  <= '0;
            swap_ack   <= 1'b0;
            swap_armed <= 1'b0;
        end else begin
            swap_ack <= swap_do;
            if (swap_do) begin
                swap_armed <= 1'b0;
            end else if (!swap_req) begin
                swap_armed <= 1'b1;
            end
            if (pix_clk) begin
                fb.rd <= draw_active;
                if (draw_active) begin
                    fb.addr <= {front_bank, offset};
                end
                {vga_r, vga_g, vga_b} <= fb.rd ? expand(fb.data) : 12'h000;
                hs_d   <= h_sync;
                vs_d   <= v_sync;
                vga_hs <= hs_d;
                vga_vs <= vs_d;
                if (screen_end) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
                if (swap_do) begin
                    front_bank <= ~front_bank;
                end
            end
        end
    end

endmodule

// File: tb/tb_fb_scan_out.sv
// Self-checking bench for fb_scan_out: directed vector table, hand-written corner sequences
// and a randomized run checked against a step-level behavioural model.
module tb_fb_scan_out;

    localparam int unsigned ADDR_W = 15;

    logic       clk = 1'b0;
    logic       rst, pix_clk, h_sync, v_sync, draw_active, screen_end, swap_req;
    logic [9:0] pix_x, pix_y;
    logic       swap_ack, front_bank, vga_hs, vga_vs;
    logic [7:0] frame_cnt;
    logic [3:0] vga_r, vga_g, vga_b;
    logic [7:0] mem [65536];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fb_scan_out_if #(.ADDR_W(ADDR_W)) fb_bus ();
    assign fb_bus.data = mem[fb_bus.addr];

    fb_scan_out #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_clk     (pix_clk),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .draw_active (draw_active),
        .screen_end  (screen_end),
        .fb          (fb_bus),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .front_bank  (front_bank),
        .frame_cnt   (frame_cnt),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs)
    );

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [7:0]  data;
        logic [15:0] addr;
        logic [3:0]  r;
        logic [3:0]  g;
        logic [3:0]  b;
    } vec_t;
    vec_t tbl [6];

    // Model: expected outputs after the coming edge, derived from the step history.
    bit          m_rd, m_hs, m_vs, m_bank, m_ack, m_fresh, last_hs, last_vs;
    bit   [15:0] m_addr;
    bit   [11:0] m_rgb;
    int unsigned m_frames;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [11:0] expand_rgb(input bit [7:0] d);
        int unsigned r3, g3, b2;
        r3 = d / 32;
        g3 = (d / 4) % 8;
        b2 = d % 4;
        return 12'((r3 * 2 + r3 / 4) * 256 + (g3 * 2 + g3 / 4) * 16 + b2 * 5);
    endfunction

    task automatic model_clk();
        bit          take;
        int unsigned off;
        if (rst) begin
            m_rd = 0; m_addr = 0; m_rgb = 0; m_hs = 1; m_vs = 1; last_hs = 1; last_vs = 1;
            m_bank = 0; m_frames = 0; m_ack = 0; m_fresh = 0;
        end else begin
            take = pix_clk && screen_end && swap_req && m_fresh;
            m_ack = take;
            if (take) m_fresh = 0;
            else if (!swap_req) m_fresh = 1;
            if (pix_clk) begin
                // Pixel fetched on the previous step is shown now.
                m_rgb = m_rd ? expand_rgb(mem[m_addr]) : 12'h000;
                m_hs = last_hs; m_vs = last_vs;
                last_hs = h_sync; last_vs = v_sync;
                m_rd = draw_active;
                if (draw_active) begin
                    off = (int'(pix_y) / 4) * 160 + (int'(pix_x) - 160) / 4;
                    m_addr = {m_bank, 15'(off)};
                end
                if (screen_end) m_frames = (m_frames + 1) % 256;
                if (take) m_bank = !m_bank;
            end
        end
    endtask

    task automatic check_model();
        check("model fb_rd", fb_bus.rd, m_rd);
        check("model fb_addr", fb_bus.addr, m_addr);
        check("model rgb", {vga_r, vga_g, vga_b}, m_rgb);
        check("model vga_hs", vga_hs, m_hs);
        check("model vga_vs", vga_vs, m_vs);
        check("model front_bank", front_bank, m_bank);
        check("model frame_cnt", frame_cnt, m_frames);
        check("model swap_ack", swap_ack, m_ack);
    endtask

    task automatic tick();
        model_clk();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic set_pix(input int x, input int y, input bit da);
        pix_clk = 1; pix_x = 10'(x); pix_y = 10'(y); draw_active = da;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst = 1; pix_clk = 0; pix_x = 0; pix_y = 0; h_sync = 1; v_sync = 1;
        draw_active = 0; screen_end = 0; swap_req = 0;

        tick();
        check("reset fb_rd", fb_bus.rd, 0);
        check("reset fb_addr", fb_bus.addr, 0);
        check("reset rgb", {vga_r, vga_g, vga_b}, 0);
        check("reset hs_vs", {vga_hs, vga_vs}, 2'b11);
        check("reset front_bank", front_bank, 0);
        check("reset frame_cnt", frame_cnt, 0);
        tick(); tick();
        rst = 0;

        // Address mapping and colour expansion table.
        tbl[0] = '{10'd160, 10'd0,   8'hE0, 16'd0,     4'hF, 4'h0, 4'h0};
        tbl[1] = '{10'd799, 10'd479, 8'h03, 16'd19199, 4'h0, 4'h0, 4'hF};
        tbl[2] = '{10'd163, 10'd0,   8'h92, 16'd0,     4'h9, 4'h9, 4'hA};
        tbl[3] = '{10'd164, 10'd0,   8'h1C, 16'd1,     4'h0, 4'hF, 4'h0};
        tbl[4] = '{10'd160, 10'd4,   8'h49, 16'd160,   4'h4, 4'h4, 4'h5};
        tbl[5] = '{10'd203, 10'd9,   8'hFF, 16'd330,   4'hF, 4'hF, 4'hF};
        for (int i = 0; i < 6; i++) begin
            mem[tbl[i].addr] = tbl[i].data;
            set_pix(tbl[i].x, tbl[i].y, 1);
            tick();
            check("tbl fb_addr", fb_bus.addr, tbl[i].addr);
            check("tbl fb_rd", fb_bus.rd, 1);
            set_pix(0, tbl[i].y, 0);
            tick();
            check("tbl rgb", {vga_r, vga_g, vga_b}, {tbl[i].r, tbl[i].g, tbl[i].b});
        end
        tick();
        check("blank rgb", {vga_r, vga_g, vga_b}, 0);

        // Sync lag: falling edge sampled on step n shows after step n+1.
        set_pix(0, 10, 0);
        tick(); tick();
        h_sync = 0; v_sync = 0;
        tick();
        check("hs lag step1", vga_hs, 1);
        tick();
        check("hs lag step2", vga_hs, 0);
        check("vs lag step2", vga_vs, 0);
        h_sync = 1; v_sync = 1;
        tick();
        check("hs rise lag1", vga_hs, 0);
        tick();
        check("hs rise lag2", vga_hs, 1);

        // Stall: pix_clk low freezes everything, even with screen_end and new positions.
        set_pix(300, 200, 1);
        tick(); tick();
        pix_clk = 0;
        for (int i = 0; i < 10; i++) begin
            pix_x = 10'($urandom_range(160, 799)); pix_y = 10'($urandom_range(0, 479));
            draw_active = 1'($urandom); h_sync = 1'($urandom); v_sync = 1'($urandom);
            screen_end = 1;
            tick();
        end
        check("stall frame_cnt", frame_cnt, 0);
        screen_end = 0; h_sync = 1; v_sync = 1;

        // Swap handshake.
        set_pix(400, 100, 1);
        swap_req = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("swap wait ack", swap_ack, 0);
            check("swap wait bank", front_bank, 0);
        end
        screen_end = 1;
        tick();
        check("swap ack", swap_ack, 1);
        check("swap bank", front_bank, 1);
        screen_end = 0;
        set_pix(160, 0, 1);
        tick();
        check("swap ack pulse", swap_ack, 0);
        check("swap new bank addr", fb_bus.addr, 16'h8000);
        screen_end = 1;
        tick();
        check("held req no reswap", front_bank, 1);
        check("held req no ack", swap_ack, 0);
        screen_end = 0; swap_req = 0;
        tick();
        swap_req = 1;
        tick();
        screen_end = 1;
        tick();
        check("second swap ack", swap_ack, 1);
        check("second swap bank", front_bank, 0);
        screen_end = 0; swap_req = 0;
        tick();

        // Randomized run against the model.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            pix_clk = ($urandom_range(0, 3) != 0);
            draw_active = 1'($urandom);
            pix_x = draw_active ? 10'($urandom_range(160, 799)) : 10'd0;
            pix_y = 10'($urandom_range(0, 479));
            h_sync = ($urandom_range(0, 7) != 0);
            v_sync = ($urandom_range(0, 7) != 0);
            screen_end = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 9) == 0) swap_req = !swap_req;
            tick();
        end
        rst = 0; screen_end = 0;

        // Make sure bank 1 is displayed, then reset mid-line with a request pending.
        if (!m_bank) begin
            set_pix(500, 300, 1);
            swap_req = 0;
            tick();
            swap_req = 1; screen_end = 1;
            tick();
            check("pre-reset swap", front_bank, 1);
            screen_end = 0;
        end
        set_pix(500, 300, 1);
        swap_req = 1;
        tick();
        rst = 1;
        tick();
        check("midline rst rgb", {vga_r, vga_g, vga_b}, 0);
        check("midline rst hs_vs", {vga_hs, vga_vs}, 2'b11);
        check("midline rst fb_rd", fb_bus.rd, 0);
        check("midline rst bank", front_bank, 0);
        tick(); tick();
        rst = 0; screen_end = 1;
        tick();
        check("dropped swap bank", front_bank, 0);
        check("dropped swap ack", swap_ack, 0);
        screen_end = 0; swap_req = 0;
        set_pix(164, 0, 1);
        tick();
        tick();
        check("resume rgb", {vga_r, vga_g, vga_b}, expand_rgb(mem[1]));

        // Frame counter wrap.
        rst = 1;
        tick();
        rst = 0;
        set_pix(0, 479, 0);
        screen_end = 1;
        for (int i = 0; i < 600; i++) tick();
        check("frame_cnt wrap", frame_cnt, 88);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
